mem_port_arbiter: RTL and testbench

- Arbitrates one single-ported unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipeline.
- Latches the winning request and holds the memory-side signals stable until the memory acknowledges with mem_ready.
- Returns read data to the winner as a one-cycle valid pulse.
- Generates the pipeline stall signal used by all pipeline register enables.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the unified memory arbiter.
// The master modport is the arbiter's view, and the slave modport is the view of the pipeline and memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_func;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_func;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall;

  modport master (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_func,
           mem_rdata, mem_ready,
    output if_valid, if_rdata, d_valid, d_rdata, mem_req, mem_we, mem_addr,
           mem_wdata, mem_func, stall
  );

  modport slave (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_func,
           mem_rdata, mem_ready,
    input  if_valid, if_rdata, d_valid, d_rdata, mem_req, mem_we, mem_addr,
           mem_wdata, mem_func, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data requests normally win, and fetch is forced through after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.master   bus
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] FUNC_WORD  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t            state_r;
  logic [3:0]        starve_cnt_r;
  logic              flush_pend_r;
  logic              if_valid_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic              d_valid_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [2:0]        mem_func_r;
  logic              grant_data_s;
  logic              grant_fetch_s;
  logic              starved_s;

  // Arbitration decode used only while idle
  always_comb begin
    grant_data_s  = 1'b0;
    grant_fetch_s = 1'b0;
    starved_s     = bus.if_req && (starve_cnt_r == STARVE_LIM);
    if (state_r == IDLE) begin
      if (bus.d_req && !starved_s) begin
        grant_data_s = 1'b1;
      end else if (bus.if_req && !bus.if_flush) begin
        grant_fetch_s = 1'b1;
      end else begin
        grant_fetch_s = 1'b0;
      end
    end else begin
      grant_data_s  = 1'b0;
      grant_fetch_s = 1'b0;
    end
  end

  // Arbiter state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      starve_cnt_r <= 4'd0;
      flush_pend_r <= 1'b0;
      if_valid_r   <= 1'b0;
      if_rdata_r   <= {DATA_W{1'b0}};
      d_valid_r    <= 1'b0;
      d_rdata_r    <= {DATA_W{1'b0}};
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      mem_func_r   <= 3'b000;
    end else begin
      if_valid_r <= 1'b0;
      d_valid_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          flush_pend_r <= 1'b0;
          if (grant_data_s) begin
            state_r     <= DATA;
            mem_req_r   <= 1'b1;
            mem_we_r    <= bus.d_we;
            mem_addr_r  <= bus.d_addr;
            mem_wdata_r <= bus.d_wdata;
            mem_func_r  <= bus.d_func;
            // Only data grants made while a fetch waits count toward starvation
            if (!bus.if_req) begin
              starve_cnt_r <= 4'd0;
            end else if (starve_cnt_r != STARVE_LIM) begin
              starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
              starve_cnt_r <= starve_cnt_r;
            end
          end else if (grant_fetch_s) begin
            state_r      <= FETCH;
            mem_req_r    <= 1'b1;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= bus.if_addr;
            mem_wdata_r  <= {DATA_W{1'b0}};
            mem_func_r   <= FUNC_WORD;
            starve_cnt_r <= 4'd0;
          end else if (!bus.if_req) begin
            starve_cnt_r <= 4'd0;
          end else begin
            starve_cnt_r <= starve_cnt_r;
          end
        end
        FETCH: begin
          if (bus.mem_ready) begin
            state_r      <= IDLE;
            mem_req_r    <= 1'b0;
            if_rdata_r   <= bus.mem_rdata;
            if_valid_r   <= !(flush_pend_r || bus.if_flush);
            flush_pend_r <= 1'b0;
          end else if (bus.if_flush) begin
            flush_pend_r <= 1'b1;
          end else begin
            flush_pend_r <= flush_pend_r;
          end
        end
        DATA: begin
          if (bus.mem_ready) begin
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
            d_valid_r <= 1'b1;
            if (!mem_we_r) begin
              d_rdata_r <= bus.mem_rdata;
            end else begin
              d_rdata_r <= d_rdata_r;
            end
          end else begin
            mem_req_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_valid  = if_valid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_valid   = d_valid_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_func  = mem_func_r;
  // Stall must drop in the same cycle as the valid pulse, so it cannot be registered
  assign bus.stall = (bus.if_req & ~if_valid_r & ~bus.if_flush) |
                     (bus.d_req & ~d_valid_r);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Each task drives one scenario and checks against hand-computed values.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_func !== 3'b000) begin
      $display("FAIL reset_mem_ctrl: req=%b we=%b func=%b, want 0 0 000", bus.mem_req, bus.mem_we, bus.mem_func);
      n_fails++;
    end
    n_checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      $display("FAIL reset_mem_bus: addr=%h wdata=%h, want 0 0", bus.mem_addr, bus.mem_wdata);
      n_fails++;
    end
    n_checks++;
    if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0 || bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      $display("FAIL reset_resp: ifv=%b dv=%b ifr=%h dr=%h, want all 0", bus.if_valid, bus.d_valid, bus.if_rdata, bus.d_rdata);
      n_fails++;
    end
    n_checks++;
    if (bus.stall !== 1'b0) begin
      $display("FAIL reset_stall: got %b want 0", bus.stall);
      n_fails++;
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    bus.if_addr = 32'h10;
    bus.if_req  = 1'b1;
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) begin
      $display("FAIL fetch_stall_n: got %b want 1", bus.stall);
      n_fails++;
    end
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0 || bus.mem_func !== 3'b010) begin
      $display("FAIL fetch_mem: req=%b addr=%h we=%b func=%b, want 1 10 0 010", bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_func);
      n_fails++;
    end
    n_checks++;
    if (bus.stall !== 1'b1 || bus.if_valid !== 1'b0) begin
      $display("FAIL fetch_n1: stall=%b ifv=%b, want 1 0", bus.stall, bus.if_valid);
      n_fails++;
    end
    bus.mem_rdata = 32'h0050_0093;
    bus.mem_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h0050_0093 || bus.mem_req !== 1'b0) begin
      $display("FAIL fetch_done: ifv=%b ifr=%h req=%b, want 1 00500093 0", bus.if_valid, bus.if_rdata, bus.mem_req);
      n_fails++;
    end
    n_checks++;
    if (bus.stall !== 1'b0) begin
      $display("FAIL fetch_stall_n2: got %b want 0", bus.stall);
      n_fails++;
    end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    n_checks++;
    if (bus.if_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      $display("FAIL fetch_pulse: ifv=%b req=%b, want 0 0", bus.if_valid, bus.mem_req);
      n_fails++;
    end
  endtask

  task automatic test_simultaneous();
    bus.if_addr = 32'h14;
    bus.d_addr  = 32'h20;
    bus.d_we    = 1'b0;
    bus.d_func  = 3'b010;
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h20 || bus.mem_we !== 1'b0) begin
      $display("FAIL simul_data_first: req=%b addr=%h we=%b, want 1 20 0", bus.mem_req, bus.mem_addr, bus.mem_we);
      n_fails++;
    end
    bus.mem_rdata = 32'h1122_3344;
    bus.mem_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h1122_3344 || bus.if_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      $display("FAIL simul_load: dv=%b dr=%h ifv=%b req=%b, want 1 11223344 0 0", bus.d_valid, bus.d_rdata, bus.if_valid, bus.mem_req);
      n_fails++;
    end
    bus.d_req     = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) begin
      $display("FAIL simul_idle_stall: got %b want 1", bus.stall);
      n_fails++;
    end
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h14 || bus.d_valid !== 1'b0) begin
      $display("FAIL simul_fetch: req=%b addr=%h dv=%b, want 1 14 0", bus.mem_req, bus.mem_addr, bus.d_valid);
      n_fails++;
    end
    bus.mem_rdata = 32'hAABB_CCDD;
    bus.mem_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'hAABB_CCDD) begin
      $display("FAIL simul_fetch_done: ifv=%b ifr=%h, want 1 aabbccdd", bus.if_valid, bus.if_rdata);
      n_fails++;
    end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_store_slow();
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h24;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_func  = 3'b010;
    bus.d_req   = 1'b1;
    bus.mem_rdata = 32'h9999_9999;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h24 ||
          bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_func !== 3'b010 || bus.d_valid !== 1'b0) begin
        $display("FAIL store_hold[%0d]: req=%b we=%b addr=%h wd=%h func=%b dv=%b", i,
                 bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_func, bus.d_valid);
        n_fails++;
      end
      bus.mem_ready = (i == 2);
      tick();
    end
    n_checks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h1122_3344 || bus.mem_req !== 1'b0) begin
      $display("FAIL store_done: dv=%b dr=%h req=%b, want 1 11223344 0", bus.d_valid, bus.d_rdata, bus.mem_req);
      n_fails++;
    end
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    n_checks++;
    if (bus.d_valid !== 1'b0) begin
      $display("FAIL store_pulse: dv=%b want 0", bus.d_valid);
      n_fails++;
    end
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr;
    bus.if_addr = 32'h40;
    bus.if_req  = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h100;
    bus.d_req   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_addr = (k < 4) ? (32'h100 + 32'(4 * k)) : 32'h40;
      tick();
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr) begin
        $display("FAIL starve_grant[%0d]: req=%b addr=%h want 1 %h", k, bus.mem_req, bus.mem_addr, exp_addr);
        n_fails++;
      end
      if (k == 3) begin
        n_checks++;
        if (dut.starve_cnt_r !== 4'd4) begin
          $display("FAIL starve_sat: cnt=%0d want 4", dut.starve_cnt_r);
          n_fails++;
        end
      end
      if (k == 4) begin
        n_checks++;
        if (dut.starve_cnt_r !== 4'd0) begin
          $display("FAIL starve_clear: cnt=%0d want 0", dut.starve_cnt_r);
          n_fails++;
        end
      end
      bus.mem_rdata = 32'h0000_0A00 + 32'(k);
      bus.mem_ready = 1'b1;
      tick();
      n_checks++;
      if ((k < 4 && (bus.d_valid !== 1'b1 || bus.if_valid !== 1'b0)) ||
          (k == 4 && (bus.if_valid !== 1'b1 || bus.d_valid !== 1'b0))) begin
        $display("FAIL starve_valid[%0d]: dv=%b ifv=%b", k, bus.d_valid, bus.if_valid);
        n_fails++;
      end
      bus.mem_ready = 1'b0;
      bus.d_addr    = 32'h100 + 32'(4 * (k + 1));
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    bus.if_addr = 32'h80;
    bus.if_req  = 1'b1;
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80) begin
      $display("FAIL flush_grant: req=%b addr=%h want 1 80", bus.mem_req, bus.mem_addr);
      n_fails++;
    end
    bus.if_flush = 1'b1;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      $display("FAIL flush_stall: got %b want 0", bus.stall);
      n_fails++;
    end
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80) begin
      $display("FAIL flush_hold: req=%b addr=%h want 1 80", bus.mem_req, bus.mem_addr);
      n_fails++;
    end
    bus.if_flush  = 1'b0;
    bus.if_req    = 1'b0;
    bus.mem_rdata = 32'hCAFE_F00D;
    bus.mem_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.if_valid !== 1'b0 || bus.if_rdata !== 32'hCAFE_F00D || bus.mem_req !== 1'b0) begin
      $display("FAIL flush_done: ifv=%b ifr=%h req=%b, want 0 cafef00d 0", bus.if_valid, bus.if_rdata, bus.mem_req);
      n_fails++;
    end
    bus.mem_ready = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_flush  = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
      $display("FAIL flush_idle: req=%b ifv=%b want 0 0", bus.mem_req, bus.if_valid);
      n_fails++;
    end
    bus.if_req   = 1'b0;
    bus.if_flush = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_data();
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h200;
    bus.d_req  = 1'b1;
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
      $display("FAIL rstmid_grant: req=%b addr=%h want 1 200", bus.mem_req, bus.mem_addr);
      n_fails++;
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      $display("FAIL rstmid_clear: req=%b addr=%h ifr=%h dr=%h, want all 0", bus.mem_req, bus.mem_addr, bus.if_rdata, bus.d_rdata);
      n_fails++;
    end
    rst           = 1'b1;
    bus.d_req     = 1'b0;
    bus.mem_rdata = 32'h5555_5555;
    bus.mem_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.d_valid !== 1'b0 || bus.if_valid !== 1'b0 || bus.d_rdata !== 32'h0 || bus.mem_req !== 1'b0) begin
      $display("FAIL rstmid_ignore: dv=%b ifv=%b dr=%h req=%b, want 0 0 0 0", bus.d_valid, bus.if_valid, bus.d_rdata, bus.mem_req);
      n_fails++;
    end
    bus.mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    rst           = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.if_flush  = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0;
    bus.d_wdata   = 32'h0;
    bus.d_func    = 3'b000;
    bus.mem_rdata = 32'h0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store_slow();
    test_starvation();
    test_flush();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
